// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arbiter
// Description : Two-master (IFU read, LSU read/write) to one-slave AXI-Lite
//               arbiter with fixed priority and one outstanding transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter (
   input  logic        clock,
   input  logic        reset,
   // IFU read channels
   input  logic [31:0] m0_araddr,
   input  logic [2:0]  m0_arsize,
   input  logic        m0_arvalid,
   output logic        m0_arready,
   output logic [31:0] m0_rdata,
   output logic [1:0]  m0_rresp,
   output logic        m0_rvalid,
   input  logic        m0_rready,
   // LSU read channels
   input  logic [31:0] m1_araddr,
   input  logic [2:0]  m1_arsize,
   input  logic        m1_arvalid,
   output logic        m1_arready,
   output logic [31:0] m1_rdata,
   output logic [1:0]  m1_rresp,
   output logic        m1_rvalid,
   input  logic        m1_rready,
   // LSU write channels
   input  logic [31:0] m1_awaddr,
   input  logic [2:0]  m1_awsize,
   input  logic        m1_awvalid,
   output logic        m1_awready,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_wvalid,
   output logic        m1_wready,
   output logic [1:0]  m1_bresp,
   output logic        m1_bvalid,
   input  logic        m1_bready,
   // Slave request channels
   output logic [31:0] s_araddr,
   output logic [2:0]  s_arsize,
   output logic        s_arvalid,
   input  logic        s_arready,
   output logic [31:0] s_awaddr,
   output logic [2:0]  s_awsize,
   output logic        s_awvalid,
   input  logic        s_awready,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_wvalid,
   input  logic        s_wready,
   // Slave response channels
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   input  logic        s_rvalid,
   output logic        s_rready,
   input  logic [1:0]  s_bresp,
   input  logic        s_bvalid,
   output logic        s_bready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_M0_RD = 2'd1,
      ST_M1_RD = 2'd2,
      ST_M1_WR = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_ar_done;
   logic   r_aw_done;
   logic   r_w_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Flags drop on the same edge that returns to IDLE so the next grant starts clean.
   always_ff @(posedge clock) begin
      if (reset || (w_state_next == ST_IDLE)) begin
         r_ar_done <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (s_arvalid && s_arready) r_ar_done <= 1'b1;
         if (s_awvalid && s_awready) r_aw_done <= 1'b1;
         if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      m0_arready   = 1'b0;
      m0_rdata     = 32'd0;
      m0_rresp     = 2'd0;
      m0_rvalid    = 1'b0;
      m1_arready   = 1'b0;
      m1_rdata     = 32'd0;
      m1_rresp     = 2'd0;
      m1_rvalid    = 1'b0;
      m1_awready   = 1'b0;
      m1_wready    = 1'b0;
      m1_bresp     = 2'd0;
      m1_bvalid    = 1'b0;
      s_araddr     = 32'd0;
      s_arsize     = 3'd0;
      s_arvalid    = 1'b0;
      s_awaddr     = 32'd0;
      s_awsize     = 3'd0;
      s_awvalid    = 1'b0;
      s_wdata      = 32'd0;
      s_wstrb      = 4'd0;
      s_wvalid     = 1'b0;
      s_rready     = 1'b0;
      s_bready     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (m1_awvalid)      w_state_next = ST_M1_WR;
            else if (m1_arvalid) w_state_next = ST_M1_RD;
            else if (m0_arvalid) w_state_next = ST_M0_RD;
         end
         ST_M0_RD: begin
            s_araddr   = m0_araddr;
            s_arsize   = m0_arsize;
            s_arvalid  = m0_arvalid & ~r_ar_done;
            m0_arready = s_arready & ~r_ar_done;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            m0_rvalid  = s_rvalid;
            s_rready   = m0_rready;
            if (s_rvalid && m0_rready) w_state_next = ST_IDLE;
         end
         ST_M1_RD: begin
            s_araddr   = m1_araddr;
            s_arsize   = m1_arsize;
            s_arvalid  = m1_arvalid & ~r_ar_done;
            m1_arready = s_arready & ~r_ar_done;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            m1_rvalid  = s_rvalid;
            s_rready   = m1_rready;
            if (s_rvalid && m1_rready) w_state_next = ST_IDLE;
         end
         ST_M1_WR: begin
            // AW and W are tracked independently so either may complete first.
            s_awaddr   = m1_awaddr;
            s_awsize   = m1_awsize;
            s_awvalid  = m1_awvalid & ~r_aw_done;
            m1_awready = s_awready & ~r_aw_done;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wvalid   = m1_wvalid & ~r_w_done;
            m1_wready  = s_wready & ~r_w_done;
            m1_bresp   = s_bresp;
            m1_bvalid  = s_bvalid;
            s_bready   = m1_bready;
            if (s_bvalid && m1_bready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arbiter
// Description : Directed self-checking bench for axi_lite_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
   logic [2:0]  m0_arsize, m1_arsize, m1_awsize;
   logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
   logic        m1_awvalid, m1_wvalid, m1_bready;
   logic [3:0]  m1_wstrb;
   logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
   logic [1:0]  s_rresp, s_bresp;

   logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
   logic        m1_awready, m1_wready, m1_bvalid;
   logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
   logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
   logic [2:0]  s_arsize, s_awsize;
   logic [3:0]  s_wstrb;
   logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;

   int n_tests = 0;
   int n_fail  = 0;
   int ar_hs = 0, aw_hs = 0, w_hs = 0;
   int ar_base, aw_base, w_base;

   always #5 clock = ~clock;

   axi_lite_arbiter dut (
      .clock(clock), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   always @(posedge clock) begin
      if (!reset) begin
         if (s_arvalid && s_arready) ar_hs <= ar_hs + 1;
         if (s_awvalid && s_awready) aw_hs <= aw_hs + 1;
         if (s_wvalid && s_wready)   w_hs  <= w_hs + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are then changed mid-cycle, away from the edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_araddr = 0; m0_arsize = 0; m0_arvalid = 0; m0_rready = 0;
      m1_araddr = 0; m1_arsize = 0; m1_arvalid = 0; m1_rready = 0;
      m1_awaddr = 0; m1_awsize = 0; m1_awvalid = 0;
      m1_wdata = 0; m1_wstrb = 0; m1_wvalid = 0; m1_bready = 0;
      s_arready = 0; s_awready = 0; s_wready = 0;
      s_rdata = 32'hFFFF_FFFF; s_rresp = 0; s_rvalid = 1; s_bresp = 0; s_bvalid = 1;

      // Reset state: slave responses present but nothing forwarded
      cyc(); cyc(); #1;
      check_eq("rst_m0_rvalid", m0_rvalid, 0);
      check_eq("rst_m0_rdata", m0_rdata, 0);
      check_eq("rst_m1_bvalid", m1_bvalid, 0);
      check_eq("rst_s_rready", s_rready, 0);
      s_rvalid = 0; s_bvalid = 0; s_rdata = 0;

      // Scenario 1: m0 read alone
      reset = 1'b0;
      m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arsize = 3'd2; #1;
      check_eq("s1_idle_arvalid", s_arvalid, 0);
      check_eq("s1_idle_araddr", s_araddr, 0);
      check_eq("s1_idle_arready", m0_arready, 0);
      cyc(); s_arready = 1; #1;
      check_eq("s1_arvalid", s_arvalid, 1);
      check_eq("s1_araddr", s_araddr, 32'h8000_0000);
      check_eq("s1_arsize", s_arsize, 2);
      check_eq("s1_m0_arready", m0_arready, 1);
      cyc(); m0_arvalid = 0; s_arready = 0;
      s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 0; m0_rready = 1; #1;
      check_eq("s1_rdata", m0_rdata, 32'h1234_5678);
      check_eq("s1_rvalid", m0_rvalid, 1);
      check_eq("s1_s_rready", s_rready, 1);
      cyc(); #1;
      check_eq("s1_idle_rvalid", m0_rvalid, 0);
      check_eq("s1_idle_rready", s_rready, 0);
      s_rvalid = 0; m0_rready = 0; s_rdata = 0;

      // Scenario 2: simultaneous requests, m1 wins
      cyc();
      m0_arvalid = 1; m0_araddr = 32'h8000_0004;
      m1_arvalid = 1; m1_araddr = 32'h2000_0010; m1_arsize = 3'd2; #1;
      check_eq("s2_idle_m1_arready", m1_arready, 0);
      cyc(); s_arready = 1; #1;
      check_eq("s2_m1_araddr", s_araddr, 32'h2000_0010);
      check_eq("s2_m1_arready", m1_arready, 1);
      check_eq("s2_m0_arready", m0_arready, 0);
      cyc(); m1_arvalid = 0; s_arready = 0;
      s_rvalid = 1; s_rdata = 32'hAAAA_5555; m1_rready = 1; #1;
      check_eq("s2_m1_rdata", m1_rdata, 32'hAAAA_5555);
      check_eq("s2_m1_rvalid", m1_rvalid, 1);
      check_eq("s2_m0_rvalid", m0_rvalid, 0);
      cyc(); s_rvalid = 0; m1_rready = 0; s_rdata = 0; #1;
      check_eq("s2_gap_arvalid", s_arvalid, 0);
      cyc(); s_arready = 1; #1;
      check_eq("s2_m0_araddr", s_araddr, 32'h8000_0004);
      check_eq("s2_m0_arready", m0_arready, 1);
      cyc(); m0_arvalid = 0; s_arready = 0;
      s_rvalid = 1; s_rdata = 32'h0BAD_F00D; m0_rready = 1; #1;
      check_eq("s2_m0_rdata", m0_rdata, 32'h0BAD_F00D);
      cyc(); s_rvalid = 0; m0_rready = 0; s_rdata = 0;

      // Scenarios 4/5: ar_done blocks repeats; error response passes through
      ar_base = ar_hs;
      m1_arvalid = 1; m1_araddr = 32'h3000_0000;
      cyc(); s_arready = 1; #1;
      check_eq("s4_arvalid", s_arvalid, 1);
      cyc(); #1;
      check_eq("s4_block1_arvalid", s_arvalid, 0);
      check_eq("s4_block1_arready", m1_arready, 0);
      cyc(); #1;
      check_eq("s4_block2_arvalid", s_arvalid, 0);
      cyc(); s_arready = 0; m1_arvalid = 0;
      s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h55; m1_rready = 1; #1;
      check_eq("s5_rresp", m1_rresp, 2'b10);
      check_eq("s5_rvalid", m1_rvalid, 1);
      check_eq("s4_ar_count", ar_hs - ar_base, 1);
      cyc(); #1;
      check_eq("s5_idle_rvalid", m1_rvalid, 0);
      s_rvalid = 0; s_rresp = 0; s_rdata = 0; m1_rready = 0;

      // Scenario 3: write, W two cycles after AW
      cyc();
      aw_base = aw_hs; w_base = w_hs;
      m1_awvalid = 1; m1_awaddr = 32'h1000_0000; m1_awsize = 3'd0;
      s_awready = 1; s_wready = 1; #1;
      check_eq("s3_idle_awvalid", s_awvalid, 0);
      check_eq("s3_idle_awready", m1_awready, 0);
      cyc(); #1;
      check_eq("s3_awvalid", s_awvalid, 1);
      check_eq("s3_awaddr", s_awaddr, 32'h1000_0000);
      check_eq("s3_awready", m1_awready, 1);
      check_eq("s3_wvalid_early", s_wvalid, 0);
      cyc(); #1;
      check_eq("s3_aw_done_block", s_awvalid, 0);
      m1_awvalid = 0; m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0001; #1;
      check_eq("s3_wvalid", s_wvalid, 1);
      check_eq("s3_wdata", s_wdata, 32'hDEAD_BEEF);
      check_eq("s3_wstrb", s_wstrb, 4'b0001);
      check_eq("s3_wready", m1_wready, 1);
      cyc(); m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'b00; m1_bready = 1; #1;
      check_eq("s3_bvalid", m1_bvalid, 1);
      check_eq("s3_bready", s_bready, 1);
      check_eq("s3_aw_count", aw_hs - aw_base, 1);
      check_eq("s3_w_count", w_hs - w_base, 1);
      cyc(); #1;
      check_eq("s3_idle_bvalid", m1_bvalid, 0);
      s_bvalid = 0; m1_bready = 0;

      // Scenario 6: reset in M1_WR after AW only
      cyc();
      m1_awvalid = 1; m1_awaddr = 32'h1000_0040; s_awready = 1; s_wready = 1;
      cyc(); #1;
      check_eq("s6_awvalid", s_awvalid, 1);
      cyc(); m1_awvalid = 0; reset = 1;
      m1_wvalid = 1; s_bvalid = 1; m1_bready = 1; s_rvalid = 1; m1_rready = 1;
      cyc(); reset = 0; #1;
      check_eq("s6_wvalid", s_wvalid, 0);
      check_eq("s6_wready", m1_wready, 0);
      check_eq("s6_bvalid", m1_bvalid, 0);
      check_eq("s6_bready", s_bready, 0);
      check_eq("s6_wdata", s_wdata, 0);
      check_eq("s6_m1_rvalid", m1_rvalid, 0);
      s_bvalid = 0; s_rvalid = 0; m1_rready = 0; m1_bready = 0;
      m1_awvalid = 1;
      cyc(); #1;
      check_eq("s6_flags_aw", s_awvalid, 1);
      check_eq("s6_flags_w", s_wvalid, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: ysyx_25010008_axi_lite_arbiter

Interface
REQ-001 SHALL have no parameters; address/data fixed at 32 bits, size field 3 bits, resp 2 bits.
REQ-002 SHALL have the following ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- m0_ar{addr 32, size 3, valid 1} in / m0_arready out 1  IFU read-address channel
- m0_r{data 32, resp 2, valid 1} out / m0_rready in 1  IFU read-data channel
- m1_ar{addr 32, size 3, valid 1} in / m1_arready out 1  LSU read-address channel
- m1_r{data 32, resp 2, valid 1} out / m1_rready in 1  LSU read-data channel
- m1_aw{addr 32, size 3, valid 1} in / m1_awready out 1  LSU write-address channel
- m1_w{data 32, strb 4, valid 1} in / m1_wready out 1  LSU write-data channel
- m1_b{resp 2, valid 1} out / m1_bready in 1  LSU write-response channel
- s_ar*, s_aw*, s_w*  out; s_arready, s_awready, s_wready  in  slave request channels, same widths
- s_r{data, resp, valid}, s_b{resp, valid}  in; s_rready, s_bready  out  slave response channels

Function
REQ-003 SHALL implement FSM states IDLE, M0_RD, M1_RD, M1_WR; exactly one transaction outstanding at the slave at any time.
REQ-004 In IDLE, arbitration SHALL be fixed priority: m1_awvalid > m1_arvalid > m0_arvalid; the chosen state is registered and takes effect the next cycle.
REQ-005 In IDLE, all master-side readys/valids and all slave-side valids/readys SHALL be 0; arbitration is zero-latency-free (1-cycle grant latency).
REQ-006 M0_RD: s_ar* = m0_ar*; m0_r* = s_r*; s_rready = m0_rready; m0_arready = s_arready gated by ~ar_done.
REQ-007 M1_RD: same as REQ-006 with m1 read channels; m0 readys/valids stay 0.
REQ-008 M1_WR: s_aw*/s_w* = m1_aw*/m1_w*; m1_b* = s_b*; s_bready = m1_bready.
REQ-009 SHALL keep flags ar_done, aw_done, w_done, set on the respective handshake and cleared on return to IDLE.
REQ-010 s_arvalid = granted arvalid & ~ar_done; s_awvalid = m1_awvalid & ~aw_done; s_wvalid = m1_wvalid & ~w_done.
REQ-011 SHALL accept AW and W in either order or in the same cycle.
REQ-012 Read grant SHALL return to IDLE in the cycle after s_rvalid & s_rready; write grant in the cycle after s_bvalid & s_bready.
REQ-013 Response channels SHALL pass s_rresp/s_bresp unmodified; the arbiter never generates or masks errors.
REQ-014 A master not granted SHALL see all its ready/valid outputs at 0; its request is held, not dropped.
REQ-015 Requests arriving during a grant SHALL wait; arbitration happens only in IDLE, so back-to-back transactions have one idle cycle between them.
REQ-016 Address/data outputs toward the slave SHALL be 0 when not granted.

Reset
REQ-017 On reset: state = IDLE, all done flags = 0, all valid/ready outputs = 0, data outputs = 0.
REQ-018 Reset mid-transaction SHALL abandon the grant immediately; no response is forwarded after reset.

Verification
REQ-019 The bench SHALL cover these scenarios:
- m0 read 0x8000_0000 alone -> s_arvalid high the cycle after m0_arvalid; rdata 0x1234_5678 reaches m0_rdata; IDLE one cycle after R handshake.
- m0_arvalid and m1_arvalid rise in the same cycle -> m1 granted first; m0 granted after m1 R handshake plus one IDLE cycle.
- m1 write 0x1000_0000, strb 0001, W valid 2 cycles after AW -> single s_aw and s_w handshake each; m1_bvalid on s_bvalid.
- s_arready held high for 3 cycles while m1_arvalid stays high -> exactly one AR handshake (ar_done blocks repeats).
- s_rresp = 2'b10 -> m1_rresp = 2'b10, FSM returns to IDLE normally.
- reset asserted in M1_WR after AW only -> next cycle all outputs 0, state IDLE, flags cleared.
